// File: rtl/sync_fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: turns the registered FIFO
// read port into a framed valid/ready stream through a 3-entry skid buffer.
module sync_fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int PKT_LEN    = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  words_out
);

   localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [PW-1:0] LAST_POS = PW'(PKT_LEN - 1);

   logic [DATA_WIDTH-1:0] mem [3];
   logic [1:0]            occ;
   logic [1:0]            head;
   logic [1:0]            tail;
   logic                  infl;
   logic [PW-1:0]         pos;
   logic                  xfer;
   logic [2:0]            pending;

   function automatic logic [1:0] nxt(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   assign xfer    = m_valid & m_ready;
   assign pending = {1'b0, occ} + {2'b00, infl};

   // Reads depend only on registered occupancy, never on m_ready.
   assign fifo_rd_en = rst_n & en & ~fifo_empty & (pending < 3'd3);

   assign m_valid = (occ != 2'd0);
   assign m_last  = m_valid & (pos == LAST_POS);

   // Head entry of the circular buffer drives the stream data.
   always_comb begin
      m_data = mem[0];
      if (head == 2'd1)
         m_data = mem[1];
      else if (head == 2'd2)
         m_data = mem[2];
   end

   // Track the word requested last cycle, landing on fifo_rd_data now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         infl <= 1'b0;
      else
         infl <= fifo_rd_en;
   end

   // Capture in-flight words at the tail, retire accepted words at the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++)
            mem[i] <= '0;
         head <= 2'd0;
         tail <= 2'd0;
         occ  <= 2'd0;
      end else begin
         if (infl) begin
            for (int i = 0; i < 3; i++)
               if (tail == 2'(i))
                  mem[i] <= fifo_rd_data;
            tail <= nxt(tail);
         end
         if (xfer)
            head <= nxt(head);
         if (infl && !xfer)
            occ <= occ + 2'd1;
         else if (!infl && xfer)
            occ <= occ - 2'd1;
      end
   end

   // Packet position: advances per accepted word, wraps after the last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pos <= '0;
      else if (xfer)
         pos <= (pos == LAST_POS) ? '0 : pos + PW'(1);
   end

   // Running count of accepted words, free-running modulo 2^CNT_WIDTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         words_out <= '0;
      else if (xfer)
         words_out <= words_out + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench for sync_fifo_stream_reader: behavioural FIFO on the read port,
// scoreboard queue filled at write time and drained by a stream monitor.
module tb_sync_fifo_stream_reader;

   localparam int DW = 8;
   localparam int PL = 4;
   localparam int CW = 16;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic [CW-1:0] words_out;

   logic [DW-1:0] fm [256];
   logic [7:0]    wp;
   logic [7:0]    rp;
   int            fcnt;
   logic          underflow;
   logic          wr_en;
   logic [DW-1:0] wr_data;

   exp_t          exp_q [$];
   exp_t          mon_e;
   int            exp_idx;
   int            acc_cnt;
   int            last_cnt;
   int            checks = 0;
   int            errors = 0;
   logic          prev_stall;
   logic [DW-1:0] prev_data;
   int            cnt;

   sync_fifo_stream_reader #(
      .DATA_WIDTH (DW),
      .PKT_LEN    (PL),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .words_out    (words_out)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (fcnt == 0);

   // Behavioural synchronous FIFO with registered read data.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp           <= '0;
         rp           <= '0;
         fcnt         <= 0;
         fifo_rd_data <= '0;
         underflow    <= 1'b0;
      end else begin
         if (fifo_rd_en) begin
            if (fcnt == 0) begin
               underflow <= 1'b1;
            end else begin
               fifo_rd_data <= fm[rp];
               rp           <= rp + 8'd1;
            end
         end
         if (wr_en) begin
            fm[wp] <= wr_data;
            wp     <= wp + 8'd1;
         end
         fcnt <= fcnt + (wr_en ? 1 : 0)
                 - ((fifo_rd_en && fcnt != 0) ? 1 : 0);
      end
   end

   task automatic chk(input string name, input longint got,
                      input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      exp_t e;
      e.d = d;
      e.l = ((exp_idx % PL) == PL - 1);
      exp_q.push_back(e);
      exp_idx++;
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      exp_idx  = 0;
      acc_cnt  = 0;
      last_cnt = 0;
      wr_en    = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_model();
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   // Stream monitor: order/framing scoreboard plus stall-stability checks.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (fifo_empty)
            chk("rd_en_while_empty", fifo_rd_en, 0);
         if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
         end
         if (m_valid && m_ready) begin
            chk("words_out_run", words_out, acc_cnt & 16'hffff);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got 0x%0h want none",
                        m_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("data", m_data, mon_e.d);
               chk("last", m_last, mon_e.l);
            end
            acc_cnt++;
            if (m_last)
               last_cnt++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   initial begin
      rst_n   = 1'b1;
      en      = 1'b0;
      m_ready = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      clear_model();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_last", m_last, 0);
      chk("rst_words", words_out, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      repeat (2) step();
      rst_n = 1'b1;
      step();

      // 1: latency and back-to-back delivery
      write_word(8'h11);
      write_word(8'h22);
      write_word(8'h33);
      en      = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      chk("t1_rd_c0", fifo_rd_en, 1);
      chk("t1_valid_c0", m_valid, 0);
      @(negedge clk);
      chk("t1_valid_c1", m_valid, 0);
      @(negedge clk);
      chk("t1_valid_c2", m_valid, 1);
      chk("t1_data_c2", m_data, 8'h11);
      @(negedge clk);
      chk("t1_valid_c3", m_valid, 1);
      @(negedge clk);
      chk("t1_valid_c4", m_valid, 1);
      repeat (3) step();
      chk("t1_words", words_out, 3);

      // 2: backpressure holds at three reads, then gapless drain
      en      = 1'b0;
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         write_word(8'h20 + 8'(i));
      en  = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (fifo_rd_en)
            cnt++;
      end
      chk("t2_rd_pulses", cnt, 3);
      chk("t2_hold_valid", m_valid, 1);
      chk("t2_hold_data", m_data, 8'h20);
      step();
      m_ready = 1'b1;
      cnt     = 0;
      repeat (8) begin
         @(negedge clk);
         if (m_valid)
            cnt++;
      end
      chk("t2_no_gaps", cnt, 8);
      repeat (3) step();
      chk("t2_words", words_out, 11);
      chk("t2_drained", exp_q.size(), 0);

      // 3: packet framing from a fresh reset
      en      = 1'b0;
      m_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 9; i++)
         write_word(8'h40 + 8'(i));
      en      = 1'b1;
      m_ready = 1'b1;
      repeat (15) step();
      chk("t3_words", words_out, 9);
      chk("t3_last_count", last_cnt, 2);
      chk("t3_pos_after", acc_cnt % PL, 1);

      // 4: empty FIFO never read, single word delivered once
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (fifo_rd_en)
            cnt++;
      end
      chk("t4_rd_empty", cnt, 0);
      step();
      write_word(8'hA5);
      repeat (5) step();
      chk("t4_words", words_out, 10);
      chk("t4_underflow", underflow, 0);
      chk("t4_drained", exp_q.size(), 0);

      // 5: alternating ready with a continuous fill
      for (int i = 0; i < 12; i++) begin
         m_ready = (i % 2 == 0);
         write_word(8'h50 + 8'(i));
      end
      for (int i = 0; i < 8; i++) begin
         m_ready = (i % 2 == 0);
         step();
      end
      m_ready = 1'b1;
      repeat (10) step();
      chk("t5_words", words_out, 22);
      chk("t5_drained", exp_q.size(), 0);

      // 6: reset with two buffered words and one in flight
      en      = 1'b0;
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++)
         write_word(8'h60 + 8'(i));
      en = 1'b1;
      repeat (3) step();
      rst_n = 1'b0;
      clear_model();
      #1;
      chk("t6_rst_valid", m_valid, 0);
      chk("t6_rst_last", m_last, 0);
      chk("t6_rst_words", words_out, 0);
      chk("t6_rst_rd_en", fifo_rd_en, 0);
      en = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 6; i++)
         write_word(8'hC1 + 8'(i));
      en = 1'b1;
      @(negedge clk);
      chk("t6_rd_on", fifo_rd_en, 1);
      step();
      en = 1'b0;
      @(negedge clk);
      chk("t6_rd_off", fifo_rd_en, 0);
      step();
      m_ready = 1'b1;
      repeat (8) step();
      chk("t6_partial_words", words_out, 1);
      en = 1'b1;
      repeat (15) step();
      chk("t6_words", words_out, 6);
      chk("t6_drained", exp_q.size(), 0);
      chk("t6_underflow", underflow, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
